// File: rtl/rv_pipe_defs.sv
// rv_pipe_defs: shared pipeline definitions (data width, register index width, result-select codes).
package rv_pipe_defs;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [1:0] RES_SRC_ALU = 2'b00;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;

endpackage

// File: rtl/regfile_array.sv
// regfile_array: integer register storage with async reset, x0 masking and two combinational read ports.
// Optional write-first bypass enabled by the WB_REGFILE_BYPASS_EN macro.
`default_nettype none

module regfile_array #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    localparam int IDX_W = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr1,
    input  logic [IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]  rdata1,
    output logic [XLEN-1:0]  rdata2
);

    logic [XLEN-1:0] regs [NREG];
    logic            hit1;
    logic            hit2;

    // Entry 0 is never written (we excludes it) and is masked on read, so it folds to a constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

`ifdef WB_REGFILE_BYPASS_EN
    assign hit1 = we && (raddr1 == waddr);
    assign hit2 = we && (raddr2 == waddr);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign rdata1 = (raddr1 == '0) ? '0 : (hit1 ? wdata : regs[raddr1]);
    assign rdata2 = (raddr2 == '0) ? '0 : (hit2 ? wdata : regs[raddr2]);

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// wb_regfile: write-back result mux, register-file commit and 64-bit retired-instruction counter.
// Macro WB_REGFILE_BYPASS_EN selects write-first read bypass; undefined gives read-old behaviour.
`default_nettype none

module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_clk_en,
    input  logic [XLEN-1:0]                  i_alu_out_w,
    input  logic [XLEN-1:0]                  i_mem_out_w,
    input  logic [XLEN-1:0]                  i_pc_p4_w,
    input  logic [rv_pipe_defs::REG_IDX_W-1:0] i_rd_w,
    input  logic                             i_reg_wr_w,
    input  logic [1:0]                       i_result_src_w,
    input  logic                             i_valid_w,
    input  logic [rv_pipe_defs::REG_IDX_W-1:0] i_rs1_d,
    input  logic [rv_pipe_defs::REG_IDX_W-1:0] i_rs2_d,
    output logic [XLEN-1:0]                  o_rd1_d,
    output logic [XLEN-1:0]                  o_rd2_d,
    output logic [XLEN-1:0]                  o_result_w,
    output logic [CNT_W-1:0]                 o_instret
);

    import rv_pipe_defs::*;

    localparam int IDX_W = $clog2(NREG);

    logic             we;
    logic [CNT_W-1:0] instret;

    always_comb begin
        o_result_w = i_alu_out_w;
        case (i_result_src_w)
            RES_SRC_MEM: o_result_w = i_mem_out_w;
            RES_SRC_PC4: o_result_w = i_pc_p4_w;
            default:     o_result_w = i_alu_out_w;
        endcase
    end

    assign we = i_clk_en & i_reg_wr_w & (i_rd_w != '0);

    regfile_array #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile_array (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .we     (we),
        .waddr  (i_rd_w[IDX_W-1:0]),
        .wdata  (o_result_w),
        .raddr1 (i_rs1_d[IDX_W-1:0]),
        .raddr2 (i_rs2_d[IDX_W-1:0]),
        .rdata1 (o_rd1_d),
        .rdata2 (o_rd2_d)
    );

    // Retirement is independent of reg_wr so stores and branches are counted; wraps silently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            instret <= '0;
        end else if (i_clk_en && i_valid_w) begin
            instret <= instret + CNT_W'(1);
        end
    end

    assign o_instret = instret;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: vector table, hand-written corner sequences and randomized run against a reference model.
`default_nettype none

module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b0;
    logic [31:0] alu = '0, mem = '0, pc4 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic        reg_wr = 1'b0, valid = 1'b0;
    logic [1:0]  src = '0;
    logic [31:0] rd1, rd2, result;
    logic [63:0] instret;
    logic [31:0] rd1_s, rd2_s, result_s;
    logic [3:0]  instret_s;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
        .i_alu_out_w(alu), .i_mem_out_w(mem), .i_pc_p4_w(pc4),
        .i_rd_w(rd), .i_reg_wr_w(reg_wr), .i_result_src_w(src), .i_valid_w(valid),
        .i_rs1_d(rs1), .i_rs2_d(rs2),
        .o_rd1_d(rd1), .o_rd2_d(rd2), .o_result_w(result), .o_instret(instret)
    );

    // Narrow-counter instance so counter wrap is reachable in a short run.
    wb_regfile #(.CNT_W(4)) dut_w (
        .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en),
        .i_alu_out_w(alu), .i_mem_out_w(mem), .i_pc_p4_w(pc4),
        .i_rd_w(rd), .i_reg_wr_w(reg_wr), .i_result_src_w(src), .i_valid_w(valid),
        .i_rs1_d(rs1), .i_rs2_d(rs2),
        .o_rd1_d(rd1_s), .o_rd2_d(rd2_s), .o_result_w(result_s), .o_instret(instret_s)
    );

    // Reference model: architectural register array plus retire count.
    logic [31:0] mregs [32];
    logic [63:0] mcnt;

    function automatic logic [31:0] ref_result();
        case (src)
            2'd1:    return mem;
            2'd2:    return pc4;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (clk_en && reg_wr && rd != 0 && idx == rd) return ref_result();
`endif
        return mregs[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mcnt = '0;
    endtask

    task automatic model_edge();
        if (clk_en && reg_wr && rd != 0) mregs[rd] = ref_result();
        if (clk_en && valid) mcnt = mcnt + 64'd1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic wr, input logic v, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                          input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2);
        clk_en = en; reg_wr = wr; valid = v; src = s;
        alu = a; mem = m; pc4 = p; rd = d; rs1 = r1; rs2 = r2;
    endtask

    // Called at a negedge with inputs set: commit edge, then counter checks.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("instret", instret, mcnt);
        chk("instret_narrow", {60'h0, instret_s}, {60'h0, mcnt[3:0]});
        @(negedge clk);
    endtask

    task automatic chk_comb(input string tag);
        #1;
        chk({tag, "_result"}, {32'h0, result}, {32'h0, ref_result()});
        chk({tag, "_rd1"}, {32'h0, rd1}, {32'h0, ref_read(rs1)});
        chk({tag, "_rd2"}, {32'h0, rd2}, {32'h0, ref_read(rs2)});
    endtask

    typedef struct {
        logic        en, wr, v;
        logic [1:0]  s;
        logic [31:0] a, m, p;
        logic [4:0]  d, r1, r2;
        logic [31:0] exp_result, exp_rd1, exp_rd2;
        logic [63:0] exp_instret;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1, 1, 1, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0,
                    32'hDEADBEEF, 32'h0, 32'h0, 64'd1};
        vecs[1] = '{1, 0, 1, 2'd1, 32'h1, 32'hCAFEF00D, 32'h4, 5'd9, 5'd5, 5'd9,
                    32'hCAFEF00D, 32'hDEADBEEF, 32'h0, 64'd2};
        vecs[2] = '{1, 1, 1, 2'd0, 32'h12345678, 32'h0, 32'h0, 5'd0, 5'd0, 5'd5,
                    32'h12345678, 32'h0, 32'hDEADBEEF, 64'd3};
        vecs[3] = '{1, 1, 0, 2'd2, 32'h0, 32'h0, 32'h104, 5'd3, 5'd0, 5'd0,
                    32'h104, 32'h0, 32'h0, 64'd3};
        vecs[4] = '{1, 1, 1, 2'd3, 32'h77, 32'h88, 32'h99, 5'd2, 5'd0, 5'd3,
                    32'h77, 32'h0, 32'h104, 64'd4};
        vecs[5] = '{0, 1, 1, 2'd0, 32'h55, 32'h0, 32'h0, 5'd2, 5'd2, 5'd0,
                    32'h55, 32'h77, 32'h0, 64'd4};
        vecs[6] = '{1, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd3,
                    32'h0, 32'h77, 32'h104, 64'd4};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_instret", instret, 64'd0);
        rs1 = 5'd5; rs2 = 5'd31; #1;
        chk("reset_rd1", {32'h0, rd1}, 64'd0);
        chk("reset_rd2", {32'h0, rd2}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].en, vecs[i].wr, vecs[i].v, vecs[i].s, vecs[i].a, vecs[i].m,
                   vecs[i].p, vecs[i].d, vecs[i].r1, vecs[i].r2);
            #1;
            chk($sformatf("vec%0d_result", i), {32'h0, result}, {32'h0, vecs[i].exp_result});
            chk($sformatf("vec%0d_rd1", i), {32'h0, rd1}, {32'h0, vecs[i].exp_rd1});
            chk($sformatf("vec%0d_rd2", i), {32'h0, rd2}, {32'h0, vecs[i].exp_rd2});
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("vec%0d_instret", i), instret, vecs[i].exp_instret);
            @(negedge clk);
        end

        // Same-cycle write/read of x7 via the mem path
        set_in(1, 1, 1, 2'd0, 32'h11, 32'h0, 32'h0, 5'd7, 5'd0, 5'd0);
        tick();
        set_in(1, 1, 1, 2'd1, 32'h0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd7, 5'd7);
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("hazard_rd1", {32'h0, rd1}, 64'hA5A5A5A5);
        chk("hazard_rd2", {32'h0, rd2}, 64'hA5A5A5A5);
`else
        chk("hazard_rd1", {32'h0, rd1}, 64'h11);
        chk("hazard_rd2", {32'h0, rd2}, 64'h11);
`endif
        tick();
        set_in(1, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);
        #1;
        chk("hazard_next_rd1", {32'h0, rd1}, 64'hA5A5A5A5);
        chk("hazard_next_rd2", {32'h0, rd2}, 64'hA5A5A5A5);
        tick();

        // Stall: two cycles held, then commit once
        begin
            logic [63:0] cnt0;
            cnt0 = mcnt;
            for (int k = 0; k < 2; k++) begin
                set_in(0, 1, 1, 2'd2, 32'h0, 32'h0, 32'h104, 5'd1, 5'd1, 5'd0);
                #1;
                chk("stall_rd1", {32'h0, rd1}, 64'h0);
                tick();
            end
            chk("stall_cnt", instret, cnt0);
            set_in(1, 1, 1, 2'd2, 32'h0, 32'h0, 32'h104, 5'd1, 5'd1, 5'd0);
            chk_comb("unstall");
            tick();
            set_in(1, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd0);
            #1;
            chk("unstall_x1", {32'h0, rd1}, 64'h104);
            chk("unstall_cnt", instret, cnt0 + 64'd1);
        end

        // Preload x3..x6, then reset mid-cycle with a write pending
        for (int r = 3; r <= 6; r++) begin
            set_in(1, 1, 1, 2'd0, 32'h1000 + r, 32'h0, 32'h0, 5'(r), 5'd0, 5'd0);
            tick();
        end
        set_in(1, 1, 1, 2'd0, 32'h999, 32'h0, 32'h0, 5'd4, 5'd4, 5'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_instret", instret, 64'd0);
        chk("rst_async_rd1", {32'h0, rd1}, 64'h0);
        chk("rst_async_rd2", {32'h0, rd2}, 64'h0);
        model_reset();
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r);
            #1;
            chk($sformatf("rst_x%0d", r), {32'h0, rd1}, 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_in(1, 0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd3);
        chk_comb("post_rst");
        tick();

        // Counter wrap on the narrow instance
        set_in(1, 0, 1, 2'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int k = 0; k < 20 && mcnt[3:0] != 4'hF; k++) tick();
        chk("wrap_full", {60'h0, instret_s}, 64'hF);
        tick();
        chk("wrap_zero", {60'h0, instret_s}, 64'h0);

        // Randomized run against the model
        for (int n = 0; n < 400; n++) begin
            logic [4:0] d;
            d = 5'($urandom_range(0, 7));
            set_in($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
                   $urandom, $urandom, $urandom, d,
                   ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
            chk_comb("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
